sobel_frame_ctrl: RTL

//  Frame sequencer for the streaming 3x3 Sobel datapath (line buffers + gradient pipeline).

---
 rtl/sobel_pkg.sv | 30 +++
 rtl/sobel_frame_ctrl_if.sv | 35 +++
 rtl/sobel_vld_pipe.sv | 33 +++
 rtl/sobel_frame_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming 3x3 Sobel block.
// Holds the frame-sequencer state encoding, size defaults and datapath widths.
package sobel_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACTIVE = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        ACTIVE = ST_ACTIVE,
        DRAIN  = ST_DRAIN,
        DONE   = ST_DONE,
        ERR    = ST_ERR
    } state_t;

    localparam int MAX_W_DEF = 512;
    localparam int MAX_H_DEF = 512;
    localparam int PIX_W     = 8;
    localparam int GRAD_W    = 11;
    localparam logic [PIX_W-1:0] CLAMP_VAL = 8'd255;

    // A 3x3 window needs at least three rows and columns; larger than the buffers is unusable.
    function automatic logic dims_ok(input int w, input int h, input int max_w, input int max_h);
        return (w >= 3) && (w <= max_w) && (h >= 3) && (h <= max_h);
    endfunction

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// Control/handshake bundle between the Sobel frame sequencer and its surroundings.
// master = sequencer side, slave = pixel source, line buffers, datapath and sink.
interface sobel_frame_ctrl_if #(
    parameter int CW = 9,
    parameter int RW = 9
);
    logic          start;
    logic [CW:0]   cfg_width;
    logic [RW:0]   cfg_height;
    logic          in_valid;
    logic          in_ready;
    logic          lb_wr_en;
    logic [CW-1:0] lb_addr;
    logic          lb_rotate;
    logic          win_valid;
    logic          dp_ce;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          cfg_err;

    modport master (
        input  start, cfg_width, cfg_height, in_valid, out_ready,
        output in_ready, lb_wr_en, lb_addr, lb_rotate, win_valid, dp_ce,
               out_valid, busy, done, cfg_err
    );

    modport slave (
        output start, cfg_width, cfg_height, in_valid, out_ready,
        input  in_ready, lb_wr_en, lb_addr, lb_rotate, win_valid, dp_ce,
               out_valid, busy, done, cfg_err
    );

endinterface

// File: rtl/sobel_vld_pipe.sv
// Result-valid shadow of the Sobel datapath: DP_LAT-bit shift register advancing on en.
// Latency DP_LAT enabled cycles; holds its contents while en is low (downstream stall).
module sobel_vld_pipe #(
    parameter int DP_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              din,
    output logic [DP_LAT-1:0] q
);

    generate
        if (DP_LAT == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (en) begin
                    q <= din;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (en) begin
                    q <= {q[DP_LAT-2:0], din};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the 3x3 Sobel datapath: raster position, line-buffer control, result valid.
// Result DP_LAT cycles after its window pixel; an unaccepted result freezes the pipe and input.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int MAX_W  = MAX_W_DEF,
    parameter int MAX_H  = MAX_H_DEF,
    parameter int DP_LAT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    sobel_frame_ctrl_if.master bus
);

    localparam int CW = $clog2(MAX_W);
    localparam int RW = $clog2(MAX_H);
    localparam logic [CW:0] ONE_W = (CW+1)'(1);
    localparam logic [RW:0] ONE_H = (RW+1)'(1);

    state_t            state;
    logic [CW:0]       w_lat;
    logic [RW:0]       h_lat;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DP_LAT-1:0] vld_sr;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic stall;
    logic dp_ce;
    logic in_ready;
    logic accept;
    logic col_last;
    logic row_last;
    logic win;
    logic cfg_ok;

    assign stall    = vld_sr[DP_LAT-1] & ~bus.out_ready;
    assign dp_ce    = ~stall & (state != IDLE);
    assign in_ready = (state == ACTIVE) & ~stall;
    assign accept   = bus.in_valid & in_ready;

    assign col_last = ({1'b0, col} == (w_lat - ONE_W));
    assign row_last = ({1'b0, row} == (h_lat - ONE_H));
    // row>=2 && col>=2 without a width-mismatched compare
    assign win      = accept & (|row[RW-1:1]) & (|col[CW-1:1]);
    assign cfg_ok   = dims_ok(int'(bus.cfg_width), int'(bus.cfg_height), MAX_W, MAX_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            w_lat  <= '0;
            h_lat  <= '0;
            col    <= '0;
            row    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (cfg_ok) begin
                            state  <= ACTIVE;
                            busy_q <= 1'b1;
                            w_lat  <= bus.cfg_width;
                            h_lat  <= bus.cfg_height;
                            col    <= '0;
                            row    <= '0;
                        end else begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        if (col_last) begin
                            col <= '0;
                            row <= row + RW'(1);
                            if (row_last) begin
                                state <= DRAIN;
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (vld_sr == '0) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    sobel_vld_pipe #(
        .DP_LAT (DP_LAT)
    ) u_vld_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dp_ce),
        .din   (win),
        .q     (vld_sr)
    );

    assign bus.in_ready  = in_ready;
    assign bus.dp_ce     = dp_ce;
    assign bus.lb_wr_en  = accept;
    assign bus.lb_addr   = col;
    assign bus.lb_rotate = accept & col_last;
    assign bus.win_valid = win;
    assign bus.out_valid = vld_sr[DP_LAT-1];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = err_q;

endmodule
